// File: rtl/loadable_program_memory.sv
// Instruction memory for the fetch stage, filled at run time from a byte stream.
// A header of BPW little-endian bytes gives the word count N, followed by N little-endian words.
module loadable_program_memory #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 2 ** (ADDR_WIDTH - $clog2(DATA_WIDTH / 8))
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  output logic                  load_done,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BPW);
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_LOAD_HDR,
    S_LOAD_BODY
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [BC_W-1:0]       r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [DATA_WIDTH-1:0] r_len;
  logic [DATA_WIDTH-1:0] r_wptr;
  logic                  r_load_done;
  logic                  r_fetch_valid;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_accept;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_in_range;
  logic                  w_mem_we;
  logic                  w_done;
  logic                  w_fetch_en;
  logic [DATA_WIDTH-1:0] w_full;
  logic [IDX_W-1:0]      w_fetch_idx;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_unused_addr;

  assign load_ready  = (r_state != S_RUN);
  assign load_done   = r_load_done;
  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = r_fetch_data;

  assign w_accept    = load_valid && load_ready;
  assign w_last_byte = (r_byte_cnt == BC_W'(BPW - 1));
  assign w_last_word = (r_wptr == r_len - DATA_WIDTH'(1));
  assign w_in_range  = (64'(r_wptr) < 64'(DEPTH_WORDS));
  assign w_mem_we    = (r_state == S_LOAD_BODY) && w_accept && w_last_byte && w_in_range;
  assign w_wr_idx    = r_wptr[IDX_W-1:0];
  // DEPTH_WORDS is a power of two, so the modulo is just the low index bits.
  assign w_fetch_idx = fetch_addr[OFF_W +: IDX_W];
  assign w_fetch_en  = (r_state == S_RUN) && !load_start;
  // Byte-offset and out-of-range upper address bits are deliberately ignored.
  assign w_unused_addr = ^fetch_addr;

  // Complete word as it will look once the current (final) byte lands.
  always_comb begin
    w_full = r_asm;
    w_full[DATA_WIDTH-8 +: 8] = load_byte;
  end

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (load_start) w_state_next = S_LOAD_HDR;
      end
      S_LOAD_HDR: begin
        if (w_accept && w_last_byte) begin
          if (w_full == '0) begin
            w_state_next = S_RUN;
            w_done       = 1'b1;
          end else begin
            w_state_next = S_LOAD_BODY;
          end
        end
      end
      S_LOAD_BODY: begin
        if (w_accept && w_last_byte && w_last_word) begin
          w_state_next = S_RUN;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_cnt    <= '0;
      r_asm         <= '0;
      r_len         <= '0;
      r_wptr        <= '0;
      r_load_done   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
    end else begin
      r_load_done <= w_done;
      if (w_accept) begin
        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
        r_asm[r_byte_cnt*8 +: 8] <= load_byte;
        if (r_state == S_LOAD_HDR && w_last_byte) r_len <= w_full;
        if (r_state == S_LOAD_BODY && w_last_byte) r_wptr <= w_last_word ? '0 : r_wptr + 1'b1;
      end
      // Stall freezes both valid and data; loading forces valid low.
      if (w_fetch_en) begin
        if (!fetch_stall) begin
          r_fetch_valid <= fetch_req;
          if (fetch_req) r_fetch_data <= r_mem[w_fetch_idx];
        end
      end else begin
        r_fetch_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_idx] <= w_full;
  end

endmodule

// File: tb/tb_loadable_program_memory.sv
// Scoreboard bench for loadable_program_memory: byte-stream loads, fetch latency/stall/wrap,
// empty loads and reset in the middle of a load.
module tb_loadable_program_memory;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** (AW - 2);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_byte = 8'h00;
  logic          load_ready;
  logic          load_done;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_stall = 1'b0;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  logic [31:0] lw [8];
  logic [31:0] held;
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  loadable_program_memory #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_done  (load_done),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise, input bit last);
    for (int i = 0; i < gap; i++) begin
      load_valid = 1'b0;
      if (noise) begin
        fetch_req  = 1'($urandom_range(0, 1));
        fetch_addr = 16'($urandom);
      end
      tick();
      check_eq("fetch_valid_gap", 64'(fetch_valid), 64'(0));
    end
    load_valid = 1'b1;
    load_byte  = b;
    if (noise) begin
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = 16'($urandom);
    end
    check_eq("load_ready_busy", 64'(load_ready), 64'(1));
    tick();
    load_valid = 1'b0;
    fetch_req  = 1'b0;
    check_eq(last ? "load_done_pulse" : "load_done_early", 64'(load_done), 64'(last));
    check_eq("fetch_valid_load", 64'(fetch_valid), 64'(0));
  endtask

  task automatic load_program(input logic [31:0] n, input bit gaps, input bit noise);
    pulse_start();
    check_eq("load_ready_hdr", 64'(load_ready), 64'(1));
    check_eq("fetch_valid_drop", 64'(fetch_valid), 64'(0));
    for (int k = 0; k < 4; k++)
      send_byte(n[k*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0, noise, (n == 0) && (k == 3));
    for (int w = 0; w < int'(n); w++) begin
      for (int k = 0; k < 4; k++)
        send_byte(lw[w][k*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0, noise,
                  (w == int'(n) - 1) && (k == 3));
      ref_mem[w] = lw[w];
    end
    tick();
    check_eq("load_done_width", 64'(load_done), 64'(0));
    check_eq("load_ready_run", 64'(load_ready), 64'(0));
    $display("load: N=%0d gaps=%0d noise=%0d", n, gaps, noise);
  endtask

  task automatic fetch_word(input logic [31:0] addr);
    int idx;
    idx        = int'((addr / 4) % DEPTH);
    fetch_req  = 1'b1;
    fetch_addr = addr[AW-1:0];
    exp_q.push_back(ref_mem[idx]);
    tick();
    fetch_req = 1'b0;
    exp_w = exp_q.pop_front();
    check_eq("fetch_valid", 64'(fetch_valid), 64'(1));
    check_eq($sformatf("fetch_data@%0h", addr), 64'(fetch_data), 64'(exp_w));
    $display("fetch: addr=%0h data=%08h expected=%08h", addr, fetch_data, exp_w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    // Reset state
    tick();
    tick();
    check_eq("rst_load_ready", 64'(load_ready), 64'(0));
    check_eq("rst_load_done", 64'(load_done), 64'(0));
    check_eq("rst_fetch_valid", 64'(fetch_valid), 64'(0));
    check_eq("rst_fetch_data", 64'(fetch_data), 64'(0));
    reset_n = 1'b1;
    tick();

    // Bytes offered while in RUN must be ignored
    load_valid = 1'b1;
    load_byte  = 8'hFF;
    tick();
    load_valid = 1'b0;
    check_eq("run_load_ready", 64'(load_ready), 64'(0));

    // Test 1: two-word program
    lw[0] = 32'h12345678;
    lw[1] = 32'hDEADBEEF;
    load_program(32'd2, 1'b0, 1'b0);
    fetch_word(32'h0);
    fetch_word(32'h4);
    tick();
    check_eq("idle_valid_low", 64'(fetch_valid), 64'(0));
    check_eq("idle_data_hold", 64'(fetch_data), 64'(32'hDEADBEEF));

    // Test 2: misaligned address and index wrap
    fetch_word(32'h6);
    fetch_word(32'(DEPTH * 4 + 4));

    // Test 3: stall holds outputs
    fetch_req  = 1'b1;
    fetch_addr = 16'h0000;
    exp_q.push_back(ref_mem[0]);
    tick();
    fetch_stall = 1'b1;
    fetch_addr  = 16'h0004;
    held = exp_q.pop_front();
    check_eq("stall_first_data", 64'(fetch_data), 64'(held));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", 64'(fetch_valid), 64'(1));
      check_eq("stall_data", 64'(fetch_data), 64'(held));
      $display("stall: cycle=%0d data=%08h", i, fetch_data);
    end
    fetch_stall = 1'b0;
    fetch_req   = 1'b0;
    fetch_word(32'h4);

    // Test 4: empty program leaves memory intact
    load_program(32'd0, 1'b0, 1'b0);
    fetch_word(32'h0);
    fetch_word(32'h4);

    // Test 5: gaps and fetch noise during load
    for (int i = 0; i < 4; i++) lw[i] = $urandom;
    load_program(32'd4, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) fetch_word(32'(i * 4));

    // Test 6: reset mid-body after six body bytes
    lw[0] = 32'hCAFEF00D;
    lw[1] = 32'h0BADC0DE;
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 2 : 0), 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(lw[0][k*8 +: 8], 0, 1'b0, 1'b0);
    ref_mem[0] = lw[0];
    for (int k = 0; k < 2; k++) send_byte(lw[1][k*8 +: 8], 0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_load_ready", 64'(load_ready), 64'(0));
    check_eq("midrst_load_done", 64'(load_done), 64'(0));
    tick();
    check_eq("midrst_no_done", 64'(load_done), 64'(0));
    #2;
    reset_n = 1'b1;
    tick();
    check_eq("midrst_after_ready", 64'(load_ready), 64'(0));
    check_eq("midrst_after_done", 64'(load_done), 64'(0));
    fetch_word(32'h0);
    fetch_word(32'h4);
    lw[0] = 32'hA5A55A5A;
    load_program(32'd1, 1'b0, 1'b0);
    fetch_word(32'h0);
    fetch_word(32'h4);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
